// File: rtl/ysyx_23060191_mem_arb_pkg.sv
// Shared defines for the NPC memory arbiter.
// Holds the datapath width, the arbiter FSM state encodings and the
// transaction-owner encodings used by the arbiter and its grant picker.
package ysyx_23060191_mem_arb_pkg;

  localparam int CPU_WIDTH = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_t;

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

endpackage

// File: rtl/ysyx_23060191_arb_pick.sv
// Combinational two-requester grant picker for the memory arbiter.
// Ports:
//   ifu_valid, lsu_valid  - pending requests
//   last_grant            - owner of the previous accept (round-robin build only)
//   ifu_grant, lsu_grant  - one-hot (or zero) grant
// Build option: YSYX_23060191_ARB_RR_EN selects round-robin on a tie;
// otherwise the LSU always wins a tie.
module ysyx_23060191_arb_pick
  import ysyx_23060191_mem_arb_pkg::*;
(
  input  logic ifu_valid,
  input  logic lsu_valid,
`ifdef YSYX_23060191_ARB_RR_EN
  input  logic last_grant,
`endif
  output logic ifu_grant,
  output logic lsu_grant
);

  // Grant selection: a lone requester always wins; a tie goes by policy.
  always_comb begin
    ifu_grant = 1'b0;
    lsu_grant = 1'b0;
    if (ifu_valid && lsu_valid) begin
`ifdef YSYX_23060191_ARB_RR_EN
      // The side that did not win last time takes the tie.
      if (last_grant == OWNER_LSU) begin
        ifu_grant = 1'b1;
      end else begin
        lsu_grant = 1'b1;
      end
`else
      lsu_grant = 1'b1;
`endif
    end else if (lsu_valid) begin
      lsu_grant = 1'b1;
    end else if (ifu_valid) begin
      ifu_grant = 1'b1;
    end else begin
      ifu_grant = 1'b0;
      lsu_grant = 1'b0;
    end
  end

endmodule

// File: rtl/ysyx_23060191_mem_arb.sv
// Single-port memory arbiter between the IFU and the LSU.
// One transaction at a time: accept (IDLE) -> present to memory (REQ)
// -> wait for the response (WAIT), which is routed back to its owner.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   ifu_req_* / ifu_addr     - fetch request handshake and address
//   ifu_resp_valid/rdata     - fetch response
//   lsu_req_* / lsu_*        - load/store request handshake and payload
//   lsu_resp_valid/rdata     - load data / store acknowledge
//   mem_req_* / mem_*        - request to memory with latched payload
//   mem_resp_valid/rdata     - memory response
// Build option: YSYX_23060191_ARB_RR_EN enables round-robin tie breaking
// with a last_grant register; undefined gives fixed LSU-over-IFU priority.
module ysyx_23060191_mem_arb
  import ysyx_23060191_mem_arb_pkg::*;
#(
  parameter int ADDR_W = CPU_WIDTH,
  parameter int DATA_W = CPU_WIDTH,
  parameter int MASK_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state;
  logic              owner;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_wen;
  logic [DATA_W-1:0] lat_wdata;
  logic [MASK_W-1:0] lat_wmask;
  logic              ifu_grant;
  logic              lsu_grant;
  logic              idle;
  logic              resp_hit;
`ifdef YSYX_23060191_ARB_RR_EN
  logic              last_grant;
`endif

  ysyx_23060191_arb_pick u_pick (
    .ifu_valid  (ifu_req_valid),
    .lsu_valid  (lsu_req_valid),
`ifdef YSYX_23060191_ARB_RR_EN
    .last_grant (last_grant),
`endif
    .ifu_grant  (ifu_grant),
    .lsu_grant  (lsu_grant)
  );

  // Ready is only offered in IDLE; the rst term keeps it low while reset
  // is held, independent of the requesters' valids.
  assign idle          = (state == ARB_IDLE) && !rst;
  assign lsu_req_ready = idle && lsu_grant;
  assign ifu_req_ready = idle && ifu_grant;

  assign mem_req_valid = (state == ARB_REQ);
  assign mem_addr      = lat_addr;
  assign mem_wen       = lat_wen;
  assign mem_wdata     = lat_wdata;
  assign mem_wmask     = lat_wmask;

  // Responses outside WAIT are stray and never reach a requester.
  assign resp_hit       = (state == ARB_WAIT) && mem_resp_valid;
  assign ifu_resp_valid = resp_hit && (owner == OWNER_IFU);
  assign lsu_resp_valid = resp_hit && (owner == OWNER_LSU);
  assign ifu_rdata      = mem_rdata;
  assign lsu_rdata      = mem_rdata;

  // Arbiter FSM with the request latches and owner tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_IDLE;
      owner     <= OWNER_IFU;
      lat_addr  <= {ADDR_W{1'b0}};
      lat_wen   <= 1'b0;
      lat_wdata <= {DATA_W{1'b0}};
      lat_wmask <= {MASK_W{1'b0}};
`ifdef YSYX_23060191_ARB_RR_EN
      last_grant <= OWNER_IFU;
`endif
    end else begin
      case (state)
        ARB_IDLE: begin
          if (lsu_req_ready) begin
            state     <= ARB_REQ;
            owner     <= OWNER_LSU;
            lat_addr  <= lsu_addr;
            lat_wen   <= lsu_wen;
            lat_wdata <= lsu_wdata;
            // Loads never carry a byte mask to memory.
            lat_wmask <= lsu_wen ? lsu_wmask : {MASK_W{1'b0}};
`ifdef YSYX_23060191_ARB_RR_EN
            last_grant <= OWNER_LSU;
`endif
          end else if (ifu_req_ready) begin
            state     <= ARB_REQ;
            owner     <= OWNER_IFU;
            lat_addr  <= ifu_addr;
            lat_wen   <= 1'b0;
            lat_wdata <= {DATA_W{1'b0}};
            lat_wmask <= {MASK_W{1'b0}};
`ifdef YSYX_23060191_ARB_RR_EN
            last_grant <= OWNER_IFU;
`endif
          end else begin
            state <= ARB_IDLE;
          end
        end
        ARB_REQ: begin
          if (mem_req_ready) begin
            state <= ARB_WAIT;
          end else begin
            state <= ARB_REQ;
          end
        end
        ARB_WAIT: begin
          if (mem_resp_valid) begin
            state <= ARB_IDLE;
          end else begin
            state <= ARB_WAIT;
          end
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060191_mem_arb.sv
// Self-checking bench for ysyx_23060191_mem_arb: directed scenarios followed
// by randomized traffic, all checked against a transaction-level model.
module tb_ysyx_23060191_mem_arb;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  ysyx_23060191_mem_arb dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_rdata      (ifu_rdata),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_addr       (lsu_addr),
    .lsu_wen        (lsu_wen),
    .lsu_wdata      (lsu_wdata),
    .lsu_wmask      (lsu_wmask),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_rdata      (lsu_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model: at most one accepted transaction, which is
  // either waiting to be taken by memory or waiting for its response.
  bit          outst;
  bit          issued;
  bit          e_lsu;
  logic [31:0] e_addr;
  logic        e_wen;
  logic [31:0] e_wdata;
  logic [3:0]  e_mask;
  bit          ifu_acc;
  bit          lsu_acc;
`ifdef YSYX_23060191_ARB_RR_EN
  bit          last_lsu;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // On a tie, does the LSU win?
  function automatic bit lsu_wins_tie();
`ifdef YSYX_23060191_ARB_RR_EN
    return !last_lsu;
`else
    return 1'b1;
`endif
  endfunction

  task automatic note_grant(input bit to_lsu);
`ifdef YSYX_23060191_ARB_RR_EN
    last_lsu = to_lsu;
`else
    if (to_lsu) begin end
`endif
  endtask

  // Check DUT outputs for the inputs currently driven, then advance the model.
  task automatic tick();
    bit exp_l;
    bit exp_i;
    #1;
    if (rst) begin
      check("rst_ifu_ready", 64'(ifu_req_ready), 64'd0);
      check("rst_lsu_ready", 64'(lsu_req_ready), 64'd0);
      check("rst_mem_valid", 64'(mem_req_valid), 64'd0);
      check("rst_ifu_resp", 64'(ifu_resp_valid), 64'd0);
      check("rst_lsu_resp", 64'(lsu_resp_valid), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      check("rst_mem_wen", 64'(mem_wen), 64'd0);
      check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      check("rst_mem_wmask", 64'(mem_wmask), 64'd0);
      outst = 0; issued = 0; ifu_acc = 0; lsu_acc = 0;
      note_grant(1'b0);
    end else if (!outst) begin
      exp_l = lsu_req_valid && (!ifu_req_valid || lsu_wins_tie());
      exp_i = ifu_req_valid && !exp_l;
      check("idle_lsu_ready", 64'(lsu_req_ready), 64'(exp_l));
      check("idle_ifu_ready", 64'(ifu_req_ready), 64'(exp_i));
      check("idle_mem_valid", 64'(mem_req_valid), 64'd0);
      check("idle_ifu_resp", 64'(ifu_resp_valid), 64'd0);
      check("idle_lsu_resp", 64'(lsu_resp_valid), 64'd0);
      ifu_acc = exp_i;
      lsu_acc = exp_l;
      if (exp_l) begin
        outst = 1; e_lsu = 1; e_addr = lsu_addr; e_wen = lsu_wen;
        e_wdata = lsu_wdata; e_mask = lsu_wen ? lsu_wmask : 4'b0000;
        note_grant(1'b1);
      end else if (exp_i) begin
        outst = 1; e_lsu = 0; e_addr = ifu_addr; e_wen = 1'b0;
        e_wdata = 32'd0; e_mask = 4'b0000;
        note_grant(1'b0);
      end
    end else begin
      ifu_acc = 0;
      lsu_acc = 0;
      check("busy_ifu_ready", 64'(ifu_req_ready), 64'd0);
      check("busy_lsu_ready", 64'(lsu_req_ready), 64'd0);
      if (!issued) begin
        check("req_mem_valid", 64'(mem_req_valid), 64'd1);
        check("req_mem_addr", 64'(mem_addr), 64'(e_addr));
        check("req_mem_wen", 64'(mem_wen), 64'(e_wen));
        check("req_mem_wmask", 64'(mem_wmask), 64'(e_mask));
        if (e_wen) check("req_mem_wdata", 64'(mem_wdata), 64'(e_wdata));
        check("req_ifu_resp", 64'(ifu_resp_valid), 64'd0);
        check("req_lsu_resp", 64'(lsu_resp_valid), 64'd0);
        if (mem_req_ready) issued = 1;
      end else begin
        check("wait_mem_valid", 64'(mem_req_valid), 64'd0);
        if (mem_resp_valid) begin
          check("resp_ifu_valid", 64'(ifu_resp_valid), 64'(!e_lsu));
          check("resp_lsu_valid", 64'(lsu_resp_valid), 64'(e_lsu));
          if (!e_lsu) check("resp_ifu_rdata", 64'(ifu_rdata), 64'(mem_rdata));
          else if (!e_wen) check("resp_lsu_rdata", 64'(lsu_rdata), 64'(mem_rdata));
          outst = 0; issued = 0;
        end else begin
          check("wait_ifu_resp", 64'(ifu_resp_valid), 64'd0);
          check("wait_lsu_resp", 64'(lsu_resp_valid), 64'd0);
        end
      end
    end
  endtask

  // One directed cycle: drive every input at the falling edge, then check.
  task automatic dcycle(input logic rs, input logic iv, input logic [31:0] ia,
                        input logic lv, input logic [31:0] la, input logic lw,
                        input logic [31:0] ld, input logic [3:0] lm,
                        input logic rdy, input logic rv, input logic [31:0] rd);
    @(negedge clk);
    rst = rs; ifu_req_valid = iv; ifu_addr = ia;
    lsu_req_valid = lv; lsu_addr = la; lsu_wen = lw; lsu_wdata = ld; lsu_wmask = lm;
    mem_req_ready = rdy; mem_resp_valid = rv; mem_rdata = rd;
    tick();
  endtask

  // Let pending requesters hold until served while memory answers promptly.
  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ifu_acc) ifu_req_valid = 1'b0;
      if (lsu_acc) lsu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      mem_resp_valid = issued;
      mem_rdata = $urandom;
      tick();
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    ifu_req_valid = 1'b0; ifu_addr = 32'd0;
    lsu_req_valid = 1'b0; lsu_addr = 32'd0; lsu_wen = 1'b0;
    lsu_wdata = 32'd0; lsu_wmask = 4'd0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'd0;
    outst = 0; issued = 0; ifu_acc = 0; lsu_acc = 0; e_lsu = 0;
    e_addr = 32'd0; e_wen = 1'b0; e_wdata = 32'd0; e_mask = 4'd0;
    note_grant(1'b0);

    // Reset state, with valids already raised.
    dcycle(1'b1, 1'b1, 32'h8000_0000, 1'b1, 32'h8000_1000, 1'b0, 32'd0, 4'd0, 1'b1, 1'b1, 32'd0);
    dcycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);

    // IFU only fetch.
    dcycle(1'b0, 1'b1, 32'h8000_0004, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b0, 32'd0);
    dcycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b0, 32'd0);
    dcycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b1, 32'h0010_0913);
    dcycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b0, 32'd0);

    // Tie, then a second tie while the IFU still waits.
    dcycle(1'b0, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_1000, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 32'd0);
    dcycle(1'b0, 1'b1, 32'h8000_0008, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b0, 32'd0);
    dcycle(1'b0, 1'b1, 32'h8000_0008, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b1, 32'h1234_5678);
    dcycle(1'b0, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_1004, 1'b0, 32'd0, 4'd0, 1'b1, 1'b0, 32'd0);
    drain(8);

    // Store under backpressure.
    dcycle(1'b0, 1'b0, 32'd0, 1'b1, 32'h8000_2000, 1'b1, 32'hDEAD_BEEF, 4'b0011, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++)
      dcycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
    dcycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b0, 32'd0);
    dcycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
    dcycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b0, 1'b1, 32'h0BAD_F00D);

    // Stray responses in IDLE and in REQ.
    dcycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    dcycle(1'b0, 1'b1, 32'h8000_000C, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b0, 1'b1, 32'd1);
    dcycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b0, 1'b1, 32'd2);
    dcycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b1, 32'd3);
    dcycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b1, 32'h0000_0073);

    // Reset while waiting for a response, then a fresh fetch.
    dcycle(1'b0, 1'b0, 32'd0, 1'b1, 32'h8000_3000, 1'b0, 32'd0, 4'd0, 1'b1, 1'b0, 32'd0);
    dcycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b0, 32'd0);
    dcycle(1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b1, 32'h5555_AAAA);
    dcycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b1, 32'h5555_AAAA);
    dcycle(1'b0, 1'b1, 32'h8000_0000, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b0, 32'd0);
    dcycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b0, 32'd0);
    dcycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b1, 32'h0000_0297);

    // Randomized traffic; requesters hold until accepted except for rare drops.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      if (!(ifu_req_valid && !ifu_acc) || $urandom_range(0, 19) == 0) begin
        ifu_req_valid = ($urandom_range(0, 99) < 50);
        ifu_addr = $urandom;
      end
      if (!(lsu_req_valid && !lsu_acc) || $urandom_range(0, 19) == 0) begin
        lsu_req_valid = ($urandom_range(0, 99) < 50);
        lsu_addr  = $urandom;
        lsu_wen   = 1'($urandom_range(0, 1));
        lsu_wdata = $urandom;
        lsu_wmask = 4'($urandom_range(0, 15));
      end
      mem_req_ready  = ($urandom_range(0, 99) < 60);
      mem_resp_valid = issued ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 15);
      mem_rdata      = $urandom;
      tick();
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
